// File: rtl/banco_registros_multipuerto.sv
// Parametrised multi-read-port register file with a post-reset clear sequencer.
// Optional macro BR_BYPASS_EN: same-cycle write data is forwarded to matching read ports.
module banco_registros_multipuerto #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_READ*ADDR_W-1:0]   Read_Reg,
    output logic [N_READ*DATA_W-1:0]   Read_data,
    input  logic                       RegWrite,
    input  logic [ADDR_W-1:0]          Write_Reg,
    input  logic [DATA_W-1:0]          Write_Data,
    output logic                       ready,
    output logic                       wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

`ifdef BR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_idx;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wr_zero_reg;

    assign wr_zero_reg = (ZERO_REG != 0) && (Write_Reg == '0);

    // Control: walk clr_idx over the whole array, then hand over to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    wr_drop <= RegWrite;
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == '1) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    wr_drop <= 1'b0;
                    ready   <= 1'b1;
                end
                default: begin
                    state   <= CLEAR;
                    clr_idx <= '0;
                    ready   <= 1'b0;
                    wr_drop <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset of its own; contents come only from the clear walk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (RegWrite && !wr_zero_reg) begin
                mem[Write_Reg] <= Write_Data;
            end
        end
    end

    for (genvar k = 0; k < N_READ; k++) begin : g_read
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = Read_Reg[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = '0;
            if (state == RUN && !((ZERO_REG != 0) && (ra == '0))) begin
                if (BYPASS && RegWrite && (ra == Write_Reg)) begin
                    rd = Write_Data;
                end else begin
                    rd = mem[ra];
                end
            end
        end

        assign Read_data[k*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_banco_registros_multipuerto.sv
// Randomised self-checking bench for banco_registros_multipuerto (default parameters).
// Compares every cycle against a reference model of the register file contract.
module tb_banco_registros_multipuerto;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int N_READ = 2;
    localparam int DEPTH  = 32;

`ifdef BR_BYPASS_EN
    localparam bit TB_BYPASS = 1'b1;
`else
    localparam bit TB_BYPASS = 1'b0;
`endif

    logic                      clk;
    logic                      rst;
    logic [N_READ*ADDR_W-1:0]  Read_Reg;
    logic [N_READ*DATA_W-1:0]  Read_data;
    logic                      RegWrite;
    logic [ADDR_W-1:0]         Write_Reg;
    logic [DATA_W-1:0]         Write_Data;
    logic                      ready;
    logic                      wr_drop;

    banco_registros_multipuerto #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .N_READ  (N_READ),
        .ZERO_REG(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Read_Reg  (Read_Reg),
        .Read_data (Read_data),
        .RegWrite  (RegWrite),
        .Write_Reg (Write_Reg),
        .Write_Data(Write_Data),
        .ready     (ready),
        .wr_drop   (wr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bank contents, cycles of clearing seen, pending drop pulse.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                clr_cnt    = 0;
    bit                exp_ready  = 1'b0;
    bit                exp_drop   = 1'b0;
    bit                model_ok   = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] expRead(input logic [ADDR_W-1:0] a, input bit we,
                                                  input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
        if (!exp_ready || a == 0)        return '0;
        if (TB_BYPASS && we && a == wa)  return wd;
        return ref_mem[a];
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
    task automatic applyStimulus(input bit r, input bit we, input logic [ADDR_W-1:0] wa,
                                 input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] ra0,
                                 input logic [ADDR_W-1:0] ra1);
        @(negedge clk);
        rst        = r;
        RegWrite   = we;
        Write_Reg  = wa;
        Write_Data = wd;
        Read_Reg   = {ra1, ra0};
        #1;
        if (model_ok) begin
            checkOutput("ready",   {31'd0, ready},   {31'd0, exp_ready});
            checkOutput("wr_drop", {31'd0, wr_drop}, {31'd0, exp_drop});
            checkOutput($sformatf("rd0[r%0d]", ra0), Read_data[0*DATA_W +: DATA_W], expRead(ra0, we, wa, wd));
            checkOutput($sformatf("rd1[r%0d]", ra1), Read_data[1*DATA_W +: DATA_W], expRead(ra1, we, wa, wd));
        end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            clr_cnt   = 0;
            exp_ready = 1'b0;
            exp_drop  = 1'b0;
            model_ok  = 1'b1;
        end else if (!exp_ready) begin
            exp_drop = we;
            clr_cnt++;
            if (clr_cnt == DEPTH) exp_ready = 1'b1;
        end else begin
            exp_drop = 1'b0;
            if (we && wa != 0) ref_mem[wa] = wd;
        end
    endtask

    task automatic idle(input logic [ADDR_W-1:0] ra0, input logic [ADDR_W-1:0] ra1);
        applyStimulus(1'b0, 1'b0, '0, '0, ra0, ra1);
    endtask

    task automatic readAll();
        for (int a = 0; a < DEPTH; a += 2) idle(ADDR_W'(a), ADDR_W'(a + 1));
    endtask

    initial begin
        rst = 1'b1; RegWrite = 1'b0; Write_Reg = '0; Write_Data = '0; Read_Reg = '0;

        // Reset for two cycles, then clear with one write attempt at cycle 10.
        applyStimulus(1'b1, 1'b0, '0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, '0, 5'd3, 5'd4);
        for (int c = 0; c < DEPTH; c++) begin
            if (c == 10)
                applyStimulus(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, ADDR_W'($urandom));
            else
                idle(ADDR_W'($urandom), ADDR_W'($urandom));
            if (c == 10) checkOutput("drop_c11", {31'd0, exp_drop}, 32'd1);
        end
        checkOutput("ready_after_clear", {31'd0, exp_ready}, 32'd1);
        readAll();

        // Basic write then dual-port read of the same register.
        applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
        idle(5'd5, 5'd5);

        // Writes to r0 are silently ignored.
        applyStimulus(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5);
        idle(5'd0, 5'd0);

        // Same-cycle write and read of r9.
        applyStimulus(1'b0, 1'b1, 5'd9, 32'h0000BEEF, 5'd9, 5'd9);
        idle(5'd9, 5'd9);

        // Random traffic; read addresses often collide with the write address.
        for (int c = 0; c < 400; c++) begin
            logic [ADDR_W-1:0] wa, ra0, ra1;
            wa  = ADDR_W'($urandom);
            ra0 = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom);
            ra1 = ($urandom_range(0, 3) == 0) ? wa : ADDR_W'($urandom);
            applyStimulus(1'b0, 1'($urandom), wa, $urandom, ra0, ra1);
        end

        // Fill, reset in RUN, reset again 5 cycles into CLEAR, then verify the re-zeroed bank.
        for (int a = 1; a < DEPTH; a++)
            applyStimulus(1'b0, 1'b1, ADDR_W'(a), 32'(a), ADDR_W'(a), 5'd0);
        readAll();
        applyStimulus(1'b1, 1'b0, '0, '0, 5'd1, 5'd2);
        for (int c = 0; c < 5; c++) idle(ADDR_W'($urandom), ADDR_W'($urandom));
        applyStimulus(1'b1, 1'b0, '0, '0, 5'd1, 5'd2);
        for (int c = 0; c < DEPTH; c++)
            applyStimulus(1'b0, 1'($urandom), ADDR_W'($urandom), $urandom,
                          ADDR_W'($urandom), ADDR_W'($urandom));
        readAll();
        idle(5'd31, 5'd30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
